// File: rtl/lcd_pkg.sv
// Shared types and constants for the character-LCD responder.
// State encoding, command opcodes, control-bit positions and the
// command decoder used by the top-level FSM.
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_BUSY  = 2'd2
  } lcd_state_e;

  typedef enum logic [2:0] {
    OP_NONE    = 3'd0,
    OP_CLEAR   = 3'd1,
    OP_HOME    = 3'd2,
    OP_ENTRY   = 3'd3,
    OP_DISPLAY = 3'd4,
    OP_SETADDR = 3'd5
  } lcd_op_e;

  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_HOME    = 8'h02;
  localparam logic [7:0] CMD_ENTRY   = 8'h04;
  localparam logic [7:0] CMD_DISPLAY = 8'h08;
  localparam logic [7:0] CMD_SETADDR = 8'h80;

  localparam int CTRL_RS = 1;
  localparam int CTRL_RW = 0;

  localparam logic [7:0] CHAR_BLANK = 8'h20;

  // Highest set opcode bit selects the command; 0x00 and 0x10-0x7F do nothing.
  function automatic lcd_op_e decode_cmd(input logic [7:0] d);
    lcd_op_e op;
    op = OP_NONE;
    if ((d & CMD_SETADDR) != 8'h00)
      op = OP_SETADDR;
    else if (d[6:4] != 3'b000)
      op = OP_NONE;
    else if ((d & CMD_DISPLAY) != 8'h00)
      op = OP_DISPLAY;
    else if ((d & CMD_ENTRY) != 8'h00)
      op = OP_ENTRY;
    else if ((d & CMD_HOME) != 8'h00)
      op = OP_HOME;
    else if (d == CMD_CLEAR)
      op = OP_CLEAR;
    return op;
  endfunction

endpackage

// File: rtl/sync_falling_edge.sv
// Multi-flop synchroniser for an asynchronous strobe, followed by a
// single-cycle pulse on each synchronised falling edge.
module sync_falling_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_synced;

  assign w_synced = r_sync[SYNC_STAGES-1];

  // Shift the async input through the synchroniser chain and keep one cycle of history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= w_synced;
    end
  end

  assign o_fall = r_prev & ~w_synced;

endmodule

// File: rtl/lcd_responder.sv
// Device-side model of an 8-bit character LCD (2 lines x 16 columns).
// Executes one command or data write per falling edge of lcd_enable,
// keeps the display buffer, cursor, busy flag and a sticky overrun flag.
// Optional simulation trace of accepted characters: define LCD_TRACE_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | blanking buffer, one cell per cycle (32 cycles), busy=1
// ST_IDLE  | ready, decodes strobes, busy=0
// ST_BUSY  | post-operation hold for BUSY_CYCLES cycles, busy=1
module lcd_responder #(
  parameter int COLS        = 16,
  parameter int BUSY_CYCLES = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] lcd_data,
  input  logic [1:0] lcd_ctrl,
  input  logic       lcd_enable,
  output logic [7:0] lcd_dout,
  output logic       busy,
  output logic       display_on,
  output logic       overrun,
  input  logic [4:0] buf_addr,
  output logic [7:0] buf_char
);

  import lcd_pkg::*;

  localparam int DEPTH = 2 * COLS;
  localparam int CNT_W = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BUSY_CYCLES - 1);

  lcd_state_e     r_state;
  lcd_state_e     w_next;
  logic [4:0]     r_cur;
  logic [4:0]     r_idx;
  logic           r_inc;
  logic           r_disp;
  logic           r_ovr;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]     r_mem [DEPTH];

  logic           w_strobe;
  logic           w_rs;
  logic           w_rw;
  lcd_op_e        w_op;
  logic           w_accept;
  logic           w_acc_data;
  logic           w_acc_cmd;
  logic           w_clr_done;
  logic           w_ovr_set;
  logic [4:0]     w_cur_step;
  logic           w_busy;
  logic           w_we;
  logic [4:0]     w_waddr;
  logic [7:0]     w_wdata;

  sync_falling_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(lcd_enable),
    .o_fall (w_strobe)
  );

  assign w_rs       = lcd_ctrl[CTRL_RS];
  assign w_rw       = lcd_ctrl[CTRL_RW];
  assign w_op       = decode_cmd(lcd_data);
  assign w_accept   = w_strobe & (r_state == ST_IDLE) & ~w_rw;
  assign w_acc_data = w_accept & w_rs;
  assign w_acc_cmd  = w_accept & ~w_rs;
  assign w_clr_done = (r_state == ST_CLEAR) && (r_idx == 5'(DEPTH - 1));
  assign w_ovr_set  = w_strobe & w_busy & ~w_rw;

  // {line,col} is a 5-bit ring, so +/-1 gives the line-crossing wrap in both directions.
  assign w_cur_step = r_inc ? (r_cur + 5'd1) : (r_cur - 5'd1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_CLEAR;
    else        r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_CLEAR: if (w_clr_done) w_next = ST_IDLE;
      ST_IDLE: begin
        if (w_acc_data) begin
          w_next = ST_BUSY;
        end else if (w_acc_cmd) begin
          if (w_op == OP_CLEAR)     w_next = ST_CLEAR;
          else if (w_op != OP_NONE) w_next = ST_BUSY;
        end
      end
      ST_BUSY: if (r_cnt == '0) w_next = ST_IDLE;
      default: w_next = ST_CLEAR;
    endcase
  end

  // Outputs: busy flag and buffer write port (clear sweep has priority).
  always_comb begin
    w_busy  = (r_state != ST_IDLE);
    w_we    = 1'b0;
    w_waddr = r_cur;
    w_wdata = lcd_data;
    if (r_state == ST_CLEAR) begin
      w_we    = 1'b1;
      w_waddr = r_idx;
      w_wdata = CHAR_BLANK;
    end else if (w_acc_data) begin
      w_we = 1'b1;
    end
  end

  // Busy down-counter is preloaded while idle so it holds BUSY_CYCLES-1 on BUSY entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               r_cnt <= CNT_LOAD;
    else if (r_state == ST_IDLE)              r_cnt <= CNT_LOAD;
    else if (r_state == ST_BUSY && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end

  // Clear sweep index; parked at zero outside the sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r_idx <= '0;
    else if (r_state == ST_CLEAR) r_idx <= r_idx + 5'd1;
    else                          r_idx <= '0;
  end

  // Cursor, entry mode and display control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur  <= '0;
      r_inc  <= 1'b1;
      r_disp <= 1'b0;
    end else if (r_state == ST_CLEAR) begin
      r_cur <= '0;
      r_inc <= 1'b1;
    end else if (w_acc_data) begin
      r_cur <= w_cur_step;
    end else if (w_acc_cmd) begin
      case (w_op)
        OP_HOME:    r_cur  <= '0;
        OP_ENTRY:   r_inc  <= lcd_data[1];
        OP_DISPLAY: r_disp <= lcd_data[2];
        OP_SETADDR: if (lcd_data[5:4] == 2'b00) r_cur <= {lcd_data[6], lcd_data[3:0]};
        default:    ;
      endcase
    end
  end

  // Sticky overrun: any write strobe that lands while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_ovr <= 1'b0;
    else if (w_ovr_set) r_ovr <= 1'b1;
  end

  // Display buffer; contents are only meaningful after the first clear sweep.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

`ifdef LCD_TRACE_EN
  // Simulation-only console trace of the display stream.
  always @(posedge clk) begin
    if (rst_n) begin
      if (w_acc_data) $write("%c", lcd_data);
      if (w_acc_cmd && w_op == OP_CLEAR) $write("\n");
      if (w_ovr_set) $write("[lcd overrun]");
    end
  end
`endif

  assign lcd_dout   = {w_busy, r_cur[4], 2'b00, r_cur[3:0]};
  assign busy       = w_busy;
  assign display_on = r_disp;
  assign overrun    = r_ovr;
  assign buf_char   = r_mem[buf_addr];

endmodule
